// File: rtl/wb_pkg.sv
// Shared types and limits for the Wishbone RAM target.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_WAIT,
    WB_ACK
  } wb_target_state_t;

  localparam int unsigned WB_MAX_WAIT_STATES = 15;
  localparam int unsigned WB_WAIT_CNT_W      = 4;

endpackage

// File: rtl/wb_ram_target_if.sv
// Wishbone B4 pipelined bus between an initiator and the RAM target.
interface wb_ram_target_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10
);

  logic [ADDR_WIDTH-1:0] wb_addr_i;
  logic [DATA_WIDTH-1:0] wb_data_i;
  logic [DATA_WIDTH-1:0] wb_data_o;
  logic                  wb_we_i;
  logic                  wb_cycle_i;
  logic                  wb_strobe_i;
  logic                  wb_stall_o;
  logic                  wb_ack_o;

  modport master (
    output wb_addr_i, wb_data_i, wb_we_i, wb_cycle_i, wb_strobe_i,
    input  wb_data_o, wb_stall_o, wb_ack_o
  );

  modport slave (
    input  wb_addr_i, wb_data_i, wb_we_i, wb_cycle_i, wb_strobe_i,
    output wb_data_o, wb_stall_o, wb_ack_o
  );

endinterface

// File: rtl/wb_ram_array.sv
// Single-port synchronous RAM with a registered read port, shaped for block RAM.
module wb_ram_array #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage is never reset; only the output register is.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  // Read port only moves on a read so the last read value is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/wb_ram_target.sv
// Wishbone B4 pipelined responder with programmable wait states in front of a RAM.
module wb_ram_target
  import wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic         wb_clock_i,
  input  logic         wb_reset_i,
  wb_ram_target_if.slave bus
);

  if (WAIT_STATES > WB_MAX_WAIT_STATES) begin : g_bad_wait_states
    $error("wb_ram_target: WAIT_STATES exceeds WB_MAX_WAIT_STATES");
  end

  wb_target_state_t           state_q, state_d;
  logic [WB_WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                       stall_q, stall_d;
  logic                       ack_q, ack_d;
  logic                       ram_en;
  logic                       accept;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [DATA_WIDTH-1:0]      data_q;
  logic                       we_q;
  logic [DATA_WIDTH-1:0]      ram_rdata;

  assign accept = (state_q == WB_IDLE) && bus.wb_cycle_i && bus.wb_strobe_i;

  // Next state; the RAM access is issued on the edge that raises ack.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ram_en  = 1'b0;
    unique case (state_q)
      WB_IDLE: begin
        if (accept) begin
          state_d = WB_WAIT;
          cnt_d   = WB_WAIT_CNT_W'(WAIT_STATES);
        end
      end
      WB_WAIT: begin
        if (!bus.wb_cycle_i) begin
          state_d = WB_IDLE;
        end else if (cnt_q == '0) begin
          state_d = WB_ACK;
          ram_en  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WB_ACK: begin
        state_d = WB_IDLE;
      end
      default: begin
        state_d = WB_IDLE;
      end
    endcase
    if (wb_reset_i) begin
      ram_en = 1'b0;
    end
    stall_d = (state_d != WB_IDLE);
    ack_d   = (state_d == WB_ACK);
  end

  always_ff @(posedge wb_clock_i) begin
    if (wb_reset_i) begin
      state_q <= WB_IDLE;
      cnt_q   <= '0;
      stall_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      ack_q   <= ack_d;
    end
  end

  // Request capture; only meaningful once accepted, so no reset needed.
  always_ff @(posedge wb_clock_i) begin
    if (accept) begin
      addr_q <= bus.wb_addr_i;
      data_q <= bus.wb_data_i;
      we_q   <= bus.wb_we_i;
    end
  end

  wb_ram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (wb_clock_i),
    .rst   (wb_reset_i),
    .en    (ram_en),
    .we    (we_q),
    .addr  (addr_q),
    .wdata (data_q),
    .rdata (ram_rdata)
  );

  assign bus.wb_data_o  = ram_rdata;
  assign bus.wb_stall_o = stall_q;
  assign bus.wb_ack_o   = ack_q;

endmodule

// File: tb/tb_wb_ram_target.sv
// Bench for wb_ram_target: three targets (0, 1 and 3 wait states) against a transaction-age model.
module tb_wb_ram_target;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 10;
  localparam int          NDUT = 3;

  function automatic int ws_of(input int k);
    case (k)
      0:       return 0;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst   [NDUT];
  logic          cyc   [NDUT];
  logic          stb   [NDUT];
  logic          we    [NDUT];
  logic [AW-1:0] addr  [NDUT];
  logic [DW-1:0] wdat  [NDUT];
  logic          ack   [NDUT];
  logic          stall [NDUT];
  logic [DW-1:0] rdat  [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    wb_ram_target_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    assign bus.wb_addr_i   = addr[g];
    assign bus.wb_data_i   = wdat[g];
    assign bus.wb_we_i     = we[g];
    assign bus.wb_cycle_i  = cyc[g];
    assign bus.wb_strobe_i = stb[g];
    assign ack[g]          = bus.wb_ack_o;
    assign stall[g]        = bus.wb_stall_o;
    assign rdat[g]         = bus.wb_data_o;

    wb_ram_target #(
      .DATA_WIDTH  (DW),
      .ADDR_WIDTH  (AW),
      .WAIT_STATES (ws_of(g))
    ) dut (
      .wb_clock_i (clk),
      .wb_reset_i (rst[g]),
      .bus        (bus)
    );
  end

  // Model: a request accepted at edge A acks at edge A+W+1 and frees the bus at A+W+2.
  logic          m_busy  [NDUT];
  int            m_acc   [NDUT];
  logic          m_we    [NDUT];
  logic [AW-1:0] m_addr  [NDUT];
  logic [DW-1:0] m_wdat  [NDUT];
  logic          m_ack   [NDUT];
  logic          m_stall [NDUT];
  logic [DW-1:0] m_data  [NDUT];
  logic [DW-1:0] m_mem   [NDUT][1024];
  int            edge_n = 0;

  always @(posedge clk) begin
    edge_n = edge_n + 1;
    for (int k = 0; k < NDUT; k++) begin
      int age;
      int w;
      w = ws_of(k);
      if (rst[k]) begin
        m_busy[k] = 1'b0; m_ack[k] = 1'b0; m_stall[k] = 1'b0; m_data[k] = '0;
      end else if (m_busy[k]) begin
        age = edge_n - m_acc[k];
        if (age <= w + 1 && !cyc[k]) begin
          m_busy[k] = 1'b0; m_ack[k] = 1'b0; m_stall[k] = 1'b0;
        end else if (age == w + 1) begin
          m_ack[k] = 1'b1;
          if (m_we[k]) m_mem[k][m_addr[k]] = m_wdat[k];
          else         m_data[k] = m_mem[k][m_addr[k]];
        end else if (age == w + 2) begin
          m_busy[k] = 1'b0; m_ack[k] = 1'b0; m_stall[k] = 1'b0;
        end
      end else if (cyc[k] && stb[k]) begin
        m_busy[k] = 1'b1; m_acc[k] = edge_n; m_stall[k] = 1'b1;
        m_we[k] = we[k]; m_addr[k] = addr[k]; m_wdat[k] = wdat[k];
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic xfer(input int k, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, output logic [DW-1:0] rd, output int lat);
    bit acc;
    int acc_i;
    bit s;
    acc = 1'b0; acc_i = 0; lat = -1; rd = '0;
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; addr[k] = a; wdat[k] = d;
    for (int i = 0; i < 40; i++) begin
      s = stall[k];
      @(posedge clk); #1;
      if (!acc) begin
        if (!s) begin acc = 1'b1; acc_i = i; stb[k] = 1'b0; end
      end else if (ack[k]) begin
        lat = i - acc_i; rd = rdat[k]; break;
      end
    end
    @(posedge clk); #1;
    check($sformatf("dut%0d ack_single_cycle", k), 32'(ack[k]), 32'd0);
    cyc[k] = 1'b0; stb[k] = 1'b0;
    @(negedge clk);
  endtask

  task automatic pipe2(input int k);
    int acc_e [2];
    int ack_e [2];
    int n_acc, n_ack, stall_hi, w;
    bit s;
    n_acc = 0; n_ack = 0; stall_hi = 0; w = ws_of(k);
    acc_e[0] = -100; acc_e[1] = -100; ack_e[0] = -100; ack_e[1] = -100;
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = 1'b1; addr[k] = AW'(1); wdat[k] = 8'h11;
    for (int i = 0; i < 80; i++) begin
      s = stall[k];
      @(posedge clk); #1;
      if (s) stall_hi++;
      if (!s && stb[k]) begin
        acc_e[n_acc] = i; n_acc++;
        if (n_acc == 1) begin addr[k] = AW'(2); wdat[k] = 8'h22; end
        else stb[k] = 1'b0;
      end
      if (ack[k]) begin
        ack_e[n_ack] = i; n_ack++;
        if (n_ack == 2) break;
      end
    end
    if (stall[k]) stall_hi++;
    @(posedge clk); #1;
    cyc[k] = 1'b0;
    check($sformatf("dut%0d b2b_accepts", k), 32'(n_acc), 32'd2);
    check($sformatf("dut%0d b2b_acks", k), 32'(n_ack), 32'd2);
    check($sformatf("dut%0d b2b_latency", k), 32'(ack_e[0] - acc_e[0]), 32'(w + 1));
    check($sformatf("dut%0d b2b_second_after_idle", k), 32'(acc_e[1] - ack_e[0]), 32'd2);
    check($sformatf("dut%0d b2b_stall_cycles", k), 32'(stall_hi), 32'(2 * (w + 2)));
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] rd;
    int lat;

    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          for (int k = 0; k < NDUT; k++) begin
            check($sformatf("dut%0d cyc ack", k), 32'(ack[k]), 32'(m_ack[k]));
            check($sformatf("dut%0d cyc stall", k), 32'(stall[k]), 32'(m_stall[k]));
            if (m_ack[k] && !m_we[k])
              check($sformatf("dut%0d cyc rdata", k), 32'(rdat[k]), 32'(m_data[k]));
          end
        end
      end
      begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
    join_none

    for (int k = 0; k < NDUT; k++) begin
      rst[k] = 1'b1; cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
      addr[k] = '0; wdat[k] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("dut%0d reset ack", k), 32'(ack[k]), 32'd0);
      check($sformatf("dut%0d reset stall", k), 32'(stall[k]), 32'd0);
      check($sformatf("dut%0d reset data", k), 32'(rdat[k]), 32'h00);
      rst[k] = 1'b0;
    end
    chk_en = 1'b1;

    // Single write/read round trip on each wait-state setting.
    for (int k = 0; k < NDUT; k++) begin
      xfer(k, 1'b1, AW'(5), 8'hA5, rd, lat);
      check($sformatf("dut%0d wr_latency", k), 32'(lat), 32'(ws_of(k) + 1));
      xfer(k, 1'b0, AW'(5), 8'h00, rd, lat);
      check($sformatf("dut%0d rd_latency", k), 32'(lat), 32'(ws_of(k) + 1));
      check($sformatf("dut%0d rd_data", k), 32'(rd), 32'hA5);
    end
    xfer(0, 1'b0, AW'(5), 8'h00, rd, lat);
    check("dut0 literal_latency", 32'(lat), 32'd1);
    xfer(1, 1'b0, AW'(5), 8'h00, rd, lat);
    check("dut1 literal_latency", 32'(lat), 32'd2);
    xfer(2, 1'b0, AW'(5), 8'h00, rd, lat);
    check("dut2 literal_latency", 32'(lat), 32'd4);

    // Strobe held across two requests.
    for (int k = 0; k < NDUT; k++) begin
      pipe2(k);
      xfer(k, 1'b0, AW'(1), 8'h00, rd, lat);
      check($sformatf("dut%0d b2b_rd1", k), 32'(rd), 32'h11);
      xfer(k, 1'b0, AW'(2), 8'h00, rd, lat);
      check($sformatf("dut%0d b2b_rd2", k), 32'(rd), 32'h22);
    end

    // Cycle dropped while waiting: no ack, write not committed.
    for (int k = 0; k < NDUT; k++) begin
      xfer(k, 1'b1, AW'(10'h010), 8'h00, rd, lat);
      cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = 1'b1; addr[k] = AW'(10'h010); wdat[k] = 8'h3C;
      @(posedge clk); #1;
      stb[k] = 1'b0; cyc[k] = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        check($sformatf("dut%0d abort no_ack", k), 32'(ack[k]), 32'd0);
      end
      check($sformatf("dut%0d abort idle", k), 32'(stall[k]), 32'd0);
      @(negedge clk);
      xfer(k, 1'b0, AW'(10'h010), 8'h00, rd, lat);
      check($sformatf("dut%0d abort rd", k), 32'(rd), 32'h00);
    end

    // Reset in the middle of a write to the top address.
    xfer(2, 1'b1, AW'(10'h3FF), 8'h00, rd, lat);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; addr[2] = AW'(10'h3FF); wdat[2] = 8'h5A;
    @(posedge clk); #1;
    stb[2] = 1'b0;
    @(posedge clk); #1;
    rst[2] = 1'b1;
    @(posedge clk); #1;
    check("dut2 midreset stall", 32'(stall[2]), 32'd0);
    check("dut2 midreset ack", 32'(ack[2]), 32'd0);
    rst[2] = 1'b0; cyc[2] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("dut2 midreset no_ack", 32'(ack[2]), 32'd0);
    end
    @(negedge clk);
    xfer(2, 1'b0, AW'(10'h3FF), 8'h00, rd, lat);
    check("dut2 midreset ram_kept", 32'(rd), 32'h00);
    xfer(2, 1'b1, AW'(10'h3FF), 8'hFF, rd, lat);
    xfer(2, 1'b0, AW'(10'h3FF), 8'h00, rd, lat);
    check("dut2 top_addr_rd", 32'(rd), 32'hFF);

    // Strobe without cycle is ignored.
    for (int k = 0; k < NDUT; k++) begin
      cyc[k] = 1'b0; stb[k] = 1'b1;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        check($sformatf("dut%0d noise ack", k), 32'(ack[k]), 32'd0);
        check($sformatf("dut%0d noise stall", k), 32'(stall[k]), 32'd0);
      end
      stb[k] = 1'b0;
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
